// File: rtl/spectrum_histogram_accumulator_pkg.sv
// rtl/spectrum_histogram_accumulator_pkg.sv - shared constants and state type for the spectrum histogram
package spectrum_histogram_accumulator_pkg;

    localparam int              CNT_W      = 20;
    localparam logic [CNT_W-1:0] CNT_MAX   = 20'hFFFFF;
    localparam int              N_BINS_DEF = 1024;
    localparam int              BIN_AW_DEF = 10;

    typedef enum logic [1:0] {
        CLEAR,
        ACCUM,
        DRAIN,
        READ
    } state_t;

    // Counters pin at full scale instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/spectrum_histogram_accumulator_bin_ram.sv
// rtl/spectrum_histogram_accumulator_bin_ram.sv - N_BINS x CNT_W simple dual-port RAM with registered read
module spectrum_bin_ram #(
    parameter int N_BINS = spectrum_histogram_accumulator_pkg::N_BINS_DEF,
    parameter int BIN_AW = spectrum_histogram_accumulator_pkg::BIN_AW_DEF,
    parameter int CNT_W  = spectrum_histogram_accumulator_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [BIN_AW-1:0] waddr_i,
    input  logic [CNT_W-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [BIN_AW-1:0] raddr_i,
    output logic [CNT_W-1:0]  rdata_o
);

    logic [CNT_W-1:0] mem_q [N_BINS];
    logic [CNT_W-1:0] rdata_q;

    // Read-first: a same-address write in this cycle is not visible to the read.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spectrum_histogram_accumulator.sv
// rtl/spectrum_histogram_accumulator.sv - per-bin event counter with RMW pipeline and clear-on-read readout
module spectrum_histogram_accumulator #(
    parameter int N_BINS = spectrum_histogram_accumulator_pkg::N_BINS_DEF,
    parameter int BIN_AW = spectrum_histogram_accumulator_pkg::BIN_AW_DEF,
    parameter int CNT_W  = spectrum_histogram_accumulator_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              evt_valid,
    input  logic [BIN_AW-1:0] evt_bin,
    output logic              evt_ready,
    input  logic              start_readout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BIN_AW-1:0] out_bin,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_last,
    output logic              busy,
    output logic              sat_flag
);

    import spectrum_histogram_accumulator_pkg::*;

    localparam logic [BIN_AW-1:0] LAST_BIN = BIN_AW'(N_BINS - 1);

    state_t            state_q;
    logic [BIN_AW-1:0] clr_ptr_q;
    logic              s1_valid_q;
    logic [BIN_AW-1:0] s1_bin_q;
    logic              fwd_valid_q;
    logic [BIN_AW-1:0] fwd_bin_q;
    logic [CNT_W-1:0]  fwd_data_q;
    logic [BIN_AW-1:0] rd_ptr_q;
    logic              rd_more_q;
    logic              a_valid_q;
    logic [BIN_AW-1:0] a_bin_q;
    logic              out_valid_q;
    logic [BIN_AW-1:0] out_bin_q;
    logic [CNT_W-1:0]  out_count_q;
    logic              out_last_q;
    logic              evt_ready_q;
    logic              busy_q;
    logic              sat_q;

    logic              evt_acc;
    logic              out_hs;
    logic              b_load;
    logic              a_issue;
    logic [CNT_W-1:0]  cnt_base;
    logic [CNT_W-1:0]  cnt_inc;
    logic              cnt_sat;
    logic              ram_we;
    logic [BIN_AW-1:0] ram_waddr;
    logic [CNT_W-1:0]  ram_wdata;
    logic              ram_re;
    logic [BIN_AW-1:0] ram_raddr;
    logic [CNT_W-1:0]  ram_rdata;

    assign evt_acc = evt_valid && evt_ready_q;
    assign out_hs  = out_valid_q && out_ready;
    // Readout is a two-stage elastic pipe: RAM read register (A) feeding the output register.
    assign b_load  = a_valid_q && (!out_valid_q || out_ready);
    assign a_issue = (state_q == READ) && rd_more_q && (!a_valid_q || b_load);

    // The write issued last cycle is invisible to a read issued in that same cycle.
    assign cnt_base = (fwd_valid_q && (fwd_bin_q == s1_bin_q)) ? fwd_data_q : ram_rdata;
    assign cnt_inc  = sat_inc(cnt_base);
    assign cnt_sat  = s1_valid_q && (cnt_base == CNT_MAX);

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (state_q == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_ptr_q;
        end else if (s1_valid_q) begin
            ram_we    = 1'b1;
            ram_waddr = s1_bin_q;
            ram_wdata = cnt_inc;
        end else if (out_hs) begin
            ram_we    = 1'b1;
            ram_waddr = out_bin_q;
        end
    end

    assign ram_re    = evt_acc || a_issue;
    assign ram_raddr = (state_q == READ) ? rd_ptr_q : evt_bin;

    spectrum_bin_ram #(
        .N_BINS (N_BINS),
        .BIN_AW (BIN_AW),
        .CNT_W  (CNT_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_ptr_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_bin_q    <= '0;
            fwd_valid_q <= 1'b0;
            fwd_bin_q   <= '0;
            fwd_data_q  <= '0;
            rd_ptr_q    <= '0;
            rd_more_q   <= 1'b0;
            a_valid_q   <= 1'b0;
            a_bin_q     <= '0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
            evt_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            sat_q       <= 1'b0;
        end else begin
            s1_valid_q  <= evt_acc;
            s1_bin_q    <= evt_bin;
            fwd_valid_q <= s1_valid_q;
            fwd_bin_q   <= s1_bin_q;
            fwd_data_q  <= cnt_inc;

            if (cnt_sat) begin
                sat_q <= 1'b1;
            end else if (out_hs && (out_bin_q == '0)) begin
                sat_q <= 1'b0;
            end

            case (state_q)
                CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + BIN_AW'(1);
                    if (clr_ptr_q == LAST_BIN) begin
                        state_q     <= ACCUM;
                        evt_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (start_readout) begin
                        state_q     <= DRAIN;
                        evt_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!s1_valid_q) begin
                        state_q   <= READ;
                        rd_ptr_q  <= '0;
                        rd_more_q <= 1'b1;
                    end
                end
                READ: begin
                    if (a_issue) begin
                        rd_ptr_q  <= rd_ptr_q + BIN_AW'(1);
                        a_bin_q   <= rd_ptr_q;
                        a_valid_q <= 1'b1;
                        if (rd_ptr_q == LAST_BIN) begin
                            rd_more_q <= 1'b0;
                        end
                    end else if (b_load) begin
                        a_valid_q <= 1'b0;
                    end

                    if (b_load) begin
                        out_valid_q <= 1'b1;
                        out_bin_q   <= a_bin_q;
                        out_count_q <= ram_rdata;
                        out_last_q  <= (a_bin_q == LAST_BIN);
                    end else if (out_hs) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end

                    if (out_hs && out_last_q) begin
                        state_q     <= ACCUM;
                        evt_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign evt_ready = evt_ready_q;
    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_count = out_count_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_spectrum_histogram_accumulator.sv
// tb/tb_spectrum_histogram_accumulator.sv - scoreboard bench for spectrum_histogram_accumulator
module tb_spectrum_histogram_accumulator;

    localparam int NB = 16;
    localparam int AW = 4;
    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          evt_valid = 1'b0;
    logic [AW-1:0] evt_bin = '0;
    logic          evt_ready;
    logic          start_readout = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_bin;
    logic [CW-1:0] out_count;
    logic          out_last;
    logic          busy;
    logic          sat_flag;

    typedef struct {
        logic [AW-1:0] bin;
        logic [CW-1:0] cnt;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    logic [CW-1:0] model [NB];
    int            checks = 0;
    int            failures = 0;
    int            hs_count = 0;
    bit            pat [7] = '{1, 0, 0, 1, 1, 0, 1};

    logic          stall_q = 1'b0;
    logic [AW-1:0] hold_bin;
    logic [CW-1:0] hold_cnt;
    logic          hold_last;

    spectrum_histogram_accumulator #(
        .N_BINS (NB),
        .BIN_AW (AW),
        .CNT_W  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .evt_valid     (evt_valid),
        .evt_bin       (evt_bin),
        .evt_ready     (evt_ready),
        .start_readout (start_readout),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_bin       (out_bin),
        .out_count     (out_count),
        .out_last      (out_last),
        .busy          (busy),
        .sat_flag      (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [CW-1:0] model_inc(input logic [CW-1:0] v);
        return (v == 20'hFFFFF) ? v : v + CW'(1);
    endfunction

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_q = 1'b0;
        end else if (out_valid) begin
            if (stall_q) begin
                check("stall_bin", 32'(out_bin), 32'(hold_bin));
                check("stall_count", 32'(out_count), 32'(hold_cnt));
                check("stall_last", 32'(out_last), 32'(hold_last));
            end
            if (out_ready) begin
                hs_count++;
                stall_q = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_bin), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_bin", 32'(out_bin), 32'(e.bin));
                    check("out_count", 32'(out_count), 32'(e.cnt));
                    check("out_last", 32'(out_last), 32'(e.last));
                end
            end else begin
                stall_q   = 1'b1;
                hold_bin  = out_bin;
                hold_cnt  = out_count;
                hold_last = out_last;
            end
        end else if (stall_q) begin
            check("valid_dropped_while_stalled", 32'(out_valid), 32'd1);
            stall_q = 1'b0;
        end
    end

    task automatic apply_reset();
        int n;
        rst = 1'b1;
        evt_valid = 1'b0;
        start_readout = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_evt_ready", 32'(evt_ready), 32'd0);
        check("rst_out_bin", 32'(out_bin), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_sat_flag", 32'(sat_flag), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        for (int b = 0; b < NB; b++) model[b] = '0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < 100);
        check("clear_cycles", 32'(n), 32'(NB));
        check("accum_evt_ready", 32'(evt_ready), 32'd1);
    endtask

    task automatic send_event(input int b);
        evt_valid = 1'b1;
        evt_bin = AW'(b);
        model[b] = model_inc(model[b]);
        @(posedge clk);
        #1;
        evt_valid = 1'b0;
    endtask

    task automatic begin_readout(input bit with_evt, input int ebin, input bit drain_evt);
        exp_t e;
        if (with_evt) begin
            evt_valid = 1'b1;
            evt_bin = AW'(ebin);
            model[ebin] = model_inc(model[ebin]);
        end
        start_readout = 1'b1;
        for (int b = 0; b < NB; b++) begin
            e.bin = AW'(b);
            e.cnt = model[b];
            e.last = (b == NB - 1);
            exp_q.push_back(e);
            model[b] = '0;
        end
        @(posedge clk);
        #1;
        start_readout = 1'b0;
        evt_valid = 1'b0;
        if (drain_evt) begin
            check("drain_evt_ready", 32'(evt_ready), 32'd0);
            evt_valid = 1'b1;
            evt_bin = AW'(9);
            @(posedge clk);
            #1;
            evt_valid = 1'b0;
        end
    endtask

    task automatic finish_readout(input bit stall_mode, input int hs0);
        int n;
        n = 0;
        while (busy && n < 300) begin
            out_ready = stall_mode ? pat[n % 7] : 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b0;
        check("readout_done", 32'(busy), 32'd0);
        check("handshakes", 32'(hs_count - hs0), 32'(NB));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("post_readout_evt_ready", 32'(evt_ready), 32'd1);
    endtask

    task automatic readout(input bit stall_mode);
        int hs0;
        hs0 = hs_count;
        begin_readout(1'b0, 0, 1'b0);
        finish_readout(stall_mode, hs0);
    endtask

    initial begin
        int hs0;
        int n;

        apply_reset();
        readout(1'b0);

        send_event(3);
        send_event(3);
        send_event(3);
        send_event(7);
        readout(1'b0);
        readout(1'b0);

        evt_valid = 1'b1;
        evt_bin = AW'(5);
        @(posedge clk);
        #1;
        evt_valid = 1'b0;
        @(negedge clk);
        force dut.u_ram.rdata_q = 20'hFFFFE;
        @(posedge clk);
        #1;
        release dut.u_ram.rdata_q;
        model[5] = 20'hFFFFF;
        check("sat_before_overflow", 32'(sat_flag), 32'd0);
        send_event(5);
        @(posedge clk);
        #1;
        check("sat_set", 32'(sat_flag), 32'd1);
        readout(1'b0);
        check("sat_cleared_by_readout", 32'(sat_flag), 32'd0);

        send_event(1);
        send_event(4);
        send_event(0);
        send_event(4);
        send_event(15);
        send_event(4);
        readout(1'b1);

        send_event(10);
        send_event(12);
        send_event(12);
        begin_readout(1'b0, 0, 1'b0);
        n = 0;
        out_ready = 1'b1;
        while (!(out_valid && out_bin == AW'(8)) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_bin8", 32'(out_bin), 32'd8);
        apply_reset();
        readout(1'b0);

        hs0 = hs_count;
        begin_readout(1'b1, 2, 1'b1);
        finish_readout(1'b0, hs0);
        readout(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
